// File: rtl/seg_write_back_pkg.sv
// -----------------------------------------------------------------------------
// seg_write_back_pkg
// Shared constants for the MEM/WB stage of the 5-stage MIPS core:
//   - load-type encodings ([2] unsigned flag, [1:0] access size)
//   - WB control bus bit positions
//   - register-zero constant (writes to $0 are dropped)
// -----------------------------------------------------------------------------
package seg_write_back_pkg;

    // Access size field, i_load_type[1:0]
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b11;
    // 2'b10 is reserved and handled as a full word

    // i_load_type[2]: 1 = zero-extend, 0 = sign-extend
    localparam int LD_UNSIGNED_BIT = 2;

    // WB control bus bit positions
    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;

    // Architectural $zero
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/seg_write_back_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Purely combinational load alignment: selects byte / halfword / word out of a
// little-endian memory word and sign- or zero-extends it to LEN bits.
//
// Ports:
//   i_data       LEN      raw memory word
//   i_offset     2        byte offset (address[1:0])
//   i_load_type  NB_LOAD  [2] unsigned, [1:0] size
//   o_data       LEN      extended result
// -----------------------------------------------------------------------------
import seg_write_back_pkg::*;

module load_extend #(
    parameter int LEN     = 32,
    parameter int NB_LOAD = 3
) (
    input  logic [LEN-1:0]     i_data,
    input  logic [1:0]         i_offset,
    input  logic [NB_LOAD-1:0] i_load_type,
    output logic [LEN-1:0]     o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    assign w_unsigned = i_load_type[LD_UNSIGNED_BIT];

    always_comb begin
        w_byte = i_data[{i_offset, 3'b000} +: 8];
        // Halfword ignores address bit 0: no misalignment trap in this core
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
        o_data = i_data;
        case (i_load_type[1:0])
            LD_BYTE: o_data = w_unsigned ? {{(LEN-8){1'b0}}, w_byte}
                                         : {{(LEN-8){w_byte[7]}}, w_byte};
            LD_HALF: o_data = w_unsigned ? {{(LEN-16){1'b0}}, w_half}
                                         : {{(LEN-16){w_half[15]}}, w_half};
            default: o_data = i_data;   // LD_WORD and reserved 2'b10
        endcase
    end

endmodule

// File: rtl/seg_write_back.sv
// -----------------------------------------------------------------------------
// seg_write_back
// MEM/WB pipeline register plus write-back stage. Captures the memory-stage
// results, aligns/extends load data from the (already registered) data memory
// read port and drives the register-file write port / forwarding unit.
//
// Optional feature: define WB_RETIRE_CNT_EN to add o_retired_count, a LEN-bit
// count of register-file writes retired (wraps, cleared only by reset).
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              1 = advance, 0 = stall (hold)
//   i_flush               bubble at next edge (wins over stall)
//   i_read_data           data memory output, valid in the WB cycle
//   i_address             ALU result from MEM
//   i_write_register      destination register
//   i_ctrl_wb_bus         [RegWrite, MemtoReg]
//   i_load_type           [2] unsigned, [1:0] size
//   o_write_data          register-file write data
//   o_write_register      register-file write address
//   o_reg_write           register-file write enable ($0 suppressed)
//   o_retired_count       (WB_RETIRE_CNT_EN only) retired write count
// -----------------------------------------------------------------------------
import seg_write_back_pkg::*;

module seg_write_back #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_LOAD    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [LEN-1:0]        i_read_data,
    input  logic [LEN-1:0]        i_address,
    input  logic [NB_ADDR-1:0]    i_write_register,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_LOAD-1:0]    i_load_type,
`ifdef WB_RETIRE_CNT_EN
    output logic [LEN-1:0]        o_retired_count,
`endif
    output logic [LEN-1:0]        o_write_data,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic                  o_reg_write
);

    logic [LEN-1:0]        r_address;
    logic [NB_ADDR-1:0]    r_write_register;
    logic [NB_CTRL_WB-1:0] r_ctrl_wb;
    logic [NB_LOAD-1:0]    r_load_type;
    logic [LEN-1:0]        r_hold_data;
    logic                  r_hold_valid;

    logic [LEN-1:0]        w_read_data;
    logic [LEN-1:0]        w_load_data;
    logic                  w_reg_write;

    // -------------------------------------------------------------------------
    // Pipeline register + read-data hold register.
    // The RAM output moves on while we stall, so the first stalled edge
    // snapshots it; the snapshot is used until the stage advances again.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_address        <= '0;
            r_write_register <= '0;
            r_ctrl_wb        <= '0;
            r_load_type      <= '0;
            r_hold_data      <= '0;
            r_hold_valid     <= 1'b0;
        end else if (i_enable) begin
            r_address        <= i_address;
            r_write_register <= i_write_register;
            r_ctrl_wb        <= i_ctrl_wb_bus;
            r_load_type      <= i_load_type;
            r_hold_valid     <= 1'b0;
        end else if (!r_hold_valid) begin
            r_hold_data      <= i_read_data;
            r_hold_valid     <= 1'b1;
        end
    end

    assign w_read_data = r_hold_valid ? r_hold_data : i_read_data;

    load_extend #(
        .LEN     (LEN),
        .NB_LOAD (NB_LOAD)
    ) u_load_extend (
        .i_data      (w_read_data),
        .i_offset    (r_address[1:0]),
        .i_load_type (r_load_type),
        .o_data      (w_load_data)
    );

    assign w_reg_write      = r_ctrl_wb[REGWRITE_BIT] &&
                              (r_write_register != NB_ADDR'(REG_ZERO));
    assign o_write_data     = r_ctrl_wb[MEMTOREG_BIT] ? w_load_data : r_address;
    assign o_write_register = r_write_register;
    assign o_reg_write      = w_reg_write;

`ifdef WB_RETIRE_CNT_EN
    // Counts the write currently leaving WB; flush does not touch it.
    logic [LEN-1:0] r_retired_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_retired_count <= '0;
        else if (i_enable && w_reg_write)
            r_retired_count <= r_retired_count + 1'b1;
    end

    assign o_retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_seg_write_back.sv
// Directed-vector bench for seg_write_back. Counter checks are compiled only
// when WB_RETIRE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_seg_write_back;

    logic        clk = 1'b0;
    logic        rst, en, flush;
    logic [31:0] rdata, addr;
    logic [4:0]  wreg;
    logic [1:0]  ctrl;
    logic [2:0]  ltype;
    logic [31:0] o_wd;
    logic [4:0]  o_wr;
    logic        o_rw;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] o_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg_write_back dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (en),
        .i_flush          (flush),
        .i_read_data      (rdata),
        .i_address        (addr),
        .i_write_register (wreg),
        .i_ctrl_wb_bus    (ctrl),
        .i_load_type      (ltype),
`ifdef WB_RETIRE_CNT_EN
        .o_retired_count  (o_cnt),
`endif
        .o_write_data     (o_wd),
        .o_write_register (o_wr),
        .o_reg_write      (o_rw)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drv(input logic [31:0] a, input logic [4:0] r,
                       input logic [1:0] c, input logic [2:0] t);
        addr = a; wreg = r; ctrl = c; ltype = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] wd,
                           input logic [4:0] wr, input logic rw);
        chk({tag, ".wd"}, o_wd, wd);
        chk({tag, ".wr"}, {27'd0, o_wr}, {27'd0, wr});
        chk({tag, ".rw"}, {31'd0, o_rw}, {31'd0, rw});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; rdata = '0;
        drv(32'h0, 5'd0, 2'b00, 3'b000);
        tick(); tick();
        chk_out("reset", 32'h0, 5'd0, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        chk("reset.cnt", o_cnt, 32'h0);
`endif

        // R-type, then reset while RegWrite is registered
        rst = 1'b0;
        drv(32'h0000_00A5, 5'd7, 2'b10, 3'b011);
        tick();
        chk_out("rtype", 32'h0000_00A5, 5'd7, 1'b1);
        rst = 1'b1;
        tick();
        chk_out("rst_mid", 32'h0, 5'd0, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_mid.cnt", o_cnt, 32'h0);
`endif
        rst = 1'b0;

        // Byte loads
        rdata = 32'h80FF_7F01;
        drv(32'h0000_1003, 5'd9, 2'b11, 3'b000);
        tick();
        chk_out("lb_off3", 32'hFFFF_FF80, 5'd9, 1'b1);
        drv(32'h0000_1003, 5'd9, 2'b11, 3'b100);
        tick();
        chk("lbu_off3", o_wd, 32'h0000_0080);
        drv(32'h0000_1001, 5'd9, 2'b11, 3'b000);
        tick();
        chk("lb_off1", o_wd, 32'h0000_007F);

        // Halfword loads, bit 0 ignored
        rdata = 32'h8001_1234;
        drv(32'h0000_2003, 5'd10, 2'b11, 3'b001);
        tick();
        chk("lh_off3", o_wd, 32'hFFFF_8001);
        drv(32'h0000_2000, 5'd10, 2'b11, 3'b101);
        tick();
        chk("lhu_off0", o_wd, 32'h0000_1234);

        // Word load then 3-cycle stall with changing RAM output
        rdata = 32'hDEAD_BEEF;
        drv(32'h0000_0100, 5'd4, 2'b11, 3'b011);
        tick();
        chk_out("lw", 32'hDEAD_BEEF, 5'd4, 1'b1);
        en = 1'b0;
        tick();
        rdata = 32'h1111_1111;
        drv(32'h0000_0F0F, 5'd12, 2'b10, 3'b000);
        chk_out("stall1", 32'hDEAD_BEEF, 5'd4, 1'b1);
        tick();
        chk_out("stall2", 32'hDEAD_BEEF, 5'd4, 1'b1);
        tick();
        chk_out("stall3", 32'hDEAD_BEEF, 5'd4, 1'b1);
        flush = 1'b1;
        tick();
        chk_out("flush", 32'h0, 5'd0, 1'b0);
        flush = 1'b0; en = 1'b1;

        // Reserved size 2'b10 behaves as word
        rdata = 32'hCAFE_F00D;
        drv(32'h0000_0002, 5'd3, 2'b11, 3'b010);
        tick();
        chk_out("ld_rsvd", 32'hCAFE_F00D, 5'd3, 1'b1);

        // $0 suppression and RegWrite=0
        drv(32'h0000_0055, 5'd0, 2'b10, 3'b011);
        tick();
        chk_out("rd0", 32'h0000_0055, 5'd0, 1'b0);
        drv(32'h0000_0066, 5'd5, 2'b00, 3'b011);
        tick();
        chk_out("nowr", 32'h0000_0066, 5'd5, 1'b0);

`ifdef WB_RETIRE_CNT_EN
        // 4 writes to rd=5, one to rd=0, one stalled cycle -> count 4
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(32'h100 + i, 5'd5, 2'b10, 3'b011);
            tick();
            chk("cnt.rw", {31'd0, o_rw}, 32'd1);
        end
        drv(32'h0000_0200, 5'd0, 2'b10, 3'b011);
        tick();
        chk("cnt.rd0_rw", {31'd0, o_rw}, 32'd0);
        en = 1'b0; tick(); en = 1'b1;
        drv(32'h0, 5'd0, 2'b00, 3'b011);
        tick();
        chk("cnt.four", o_cnt, 32'd4);

        // Wrap: preload the counter just below 2^32
        @(negedge clk);
        dut.r_retired_count = 32'hFFFF_FFFE;
        drv(32'h0000_0300, 5'd5, 2'b10, 3'b011);
        tick();
        chk("cnt.pre", o_cnt, 32'hFFFF_FFFE);
        tick();
        chk("cnt.max", o_cnt, 32'hFFFF_FFFF);
        tick();
        chk("cnt.wrap", o_cnt, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
